// File: rtl/commit_trace_buffer.sv
// Commit-trace capture unit: circular history of retired instructions, frozen after a
// PC-match/external trigger and drained oldest-first. Optional macro: TRACE_CYCLE_STAMP_EN.
module commit_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            commit_pc,
  input  logic [XLEN-1:0]            commit_pc_next,
  input  logic [31:0]                commit_instr,
  input  logic                       commit_regwrite,
  input  logic                       commit_memwrite,
  input  logic                       commit_branch,
  input  logic                       commit_jump,
  input  logic [4:0]                 commit_rd,
  input  logic [XLEN-1:0]            commit_result,
  input  logic [XLEN-1:0]            commit_mem_addr,
  input  logic                       arm,
  input  logic                       trig_pc_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       trig_ext,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_data,
  output logic [3:0]                 out_flags,
  output logic [15:0]                out_cycle,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wrapped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] POST_LAST = PTR_W'((POST_TRIG == 0) ? 0 : POST_TRIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] data;
    logic [3:0]      flags;   // {jump, branch_taken, memwrite, regwrite}
  } entry_t;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wrapped_q, wrapped_d;
  logic               armed_q, armed_d;
  logic               triggered_q, triggered_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  entry_t             out_q, out_d;

  entry_t             mem_q [DEPTH];
  entry_t             wr_entry;
  logic               wr_en;
  logic               trig_hit;
  logic               rw_flag;
  logic               br_taken;
  logic               enter_done;
  logic               load_out;

`ifdef TRACE_CYCLE_STAMP_EN
  logic [15:0]        cycle_q, cycle_d;
  logic [15:0]        stamp_q [DEPTH];
  logic [15:0]        out_cycle_q, out_cycle_d;
`endif

  // Entry formatting from the retiring instruction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rw_flag  = commit_regwrite && (commit_rd != 5'd0);
    br_taken = commit_branch && (commit_pc_next != commit_pc + XLEN'(4));
    wr_entry = '0;
    wr_entry.pc    = commit_pc;
    wr_entry.instr = commit_instr;
    wr_entry.flags = {commit_jump, br_taken, commit_memwrite, rw_flag};
    if (rw_flag)              wr_entry.data = commit_result;
    else if (commit_memwrite) wr_entry.data = commit_mem_addr;
    else                      wr_entry.data = commit_pc_next;
  end

  assign trig_hit = commit_valid && ((trig_pc_en && (commit_pc == trig_pc)) || trig_ext);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_cnt_d  = post_cnt_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    wr_en       = 1'b0;
    enter_done  = 1'b0;
    load_out    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          wr_ptr_d   = '0;
          count_d    = '0;
          wrapped_d  = 1'b0;
          post_cnt_d = '0;
          state_d    = S_ARMED;
        end
      end

      S_ARMED, S_POST: begin
        if (commit_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (count_q == FULL) wrapped_d = 1'b1;
          else                 count_d   = count_q + CNT_W'(1);

          if (state_q == S_ARMED) begin
            if (trig_hit) begin
              if (POST_TRIG == 0) enter_done = 1'b1;
              else begin
                state_d    = S_POST;
                post_cnt_d = '0;
              end
            end
          end else if (post_cnt_q == POST_LAST) begin
            enter_done = 1'b1;
          end else begin
            post_cnt_d = post_cnt_q + PTR_W'(1);
          end
        end

        // Oldest surviving entry sits count slots behind the write pointer.
        if (enter_done) begin
          state_d  = S_DONE;
          rd_ptr_d = wr_ptr_d - PTR_W'(count_d);
        end
      end

      S_DONE: begin
        if (!out_valid_q) begin
          if (count_q != '0) load_out = 1'b1;
          else               state_d  = S_IDLE;
        end else if (out_ready) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            load_out = 1'b1;
          end
        end

        if (load_out) begin
          out_valid_d = 1'b1;
          out_d       = mem_q[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    armed_d     = (state_d == S_ARMED);
    triggered_d = (state_d == S_POST) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_cnt_q  <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_cnt_q  <= post_cnt_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // NOTE: trace storage is not reset; count gates which entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

`ifdef TRACE_CYCLE_STAMP_EN
  always_comb begin
    cycle_d     = cycle_q + 16'd1;
    out_cycle_d = out_cycle_q;
    if (load_out) out_cycle_d = stamp_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q     <= '0;
      out_cycle_q <= '0;
    end else begin
      cycle_q     <= cycle_d;
      out_cycle_q <= out_cycle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) stamp_q[wr_ptr_q] <= cycle_q;
  end

  assign out_cycle = out_cycle_q;
`else
  assign out_cycle = 16'd0;
`endif

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;
  assign out_data  = out_q.data;
  assign out_flags = out_q.flags;
  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign count     = count_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (DEPTH=8, POST_TRIG=2): wrap/trigger/drain,
// backpressure, entry flags, reset during capture and cycle stamps.
module tb_commit_trace_buffer;

  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int POST_TRIG = 2;

  logic clk = 1'b0;
  logic reset;
  logic commit_valid;
  logic [XLEN-1:0] commit_pc, commit_pc_next, commit_result, commit_mem_addr, trig_pc;
  logic [31:0] commit_instr;
  logic commit_regwrite, commit_memwrite, commit_branch, commit_jump;
  logic [4:0] commit_rd;
  logic arm, trig_pc_en, trig_ext, out_ready;
  logic out_valid, armed, triggered, done, wrapped;
  logic [XLEN-1:0] out_pc, out_data;
  logic [31:0] out_instr;
  logic [3:0] out_flags;
  logic [15:0] out_cycle;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;
  logic [15:0] prev_cycle;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
    .commit_instr(commit_instr), .commit_regwrite(commit_regwrite),
    .commit_memwrite(commit_memwrite), .commit_branch(commit_branch),
    .commit_jump(commit_jump), .commit_rd(commit_rd), .commit_result(commit_result),
    .commit_mem_addr(commit_mem_addr), .arm(arm), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .trig_ext(trig_ext), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data), .out_flags(out_flags),
    .out_cycle(out_cycle), .armed(armed), .triggered(triggered), .done(done),
    .count(count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // ctl = {jump, branch, memwrite, regwrite}
  task automatic do_commit(input logic [31:0] pc, input logic [31:0] pc_next,
                           input logic [3:0] ctl, input logic [4:0] rd,
                           input logic [31:0] result, input logic [31:0] addr,
                           input logic ext);
    commit_valid    = 1'b1;
    commit_pc       = pc;
    commit_pc_next  = pc_next;
    commit_instr    = {pc[29:0], 2'b11};
    {commit_jump, commit_branch, commit_memwrite, commit_regwrite} = ctl;
    commit_rd       = rd;
    commit_result   = result;
    commit_mem_addr = addr;
    trig_ext        = ext;
    tick();
    commit_valid = 1'b0;
    trig_ext     = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] pc,
                           input logic [3:0] flags, input logic [31:0] data);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, {pc[29:0], 2'b11});
    check({tag, "_flags"}, out_flags, flags);
    check({tag, "_data"}, out_data, data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_pc_next = '0;
    commit_instr = '0; commit_regwrite = 1'b0; commit_memwrite = 1'b0;
    commit_branch = 1'b0; commit_jump = 1'b0; commit_rd = '0; commit_result = '0;
    commit_mem_addr = '0; arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0;
    trig_ext = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_armed", armed, 1'b0);
    check("rst_triggered", triggered, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 0);
    check("rst_wrapped", wrapped, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    tick();

    // Wrap + PC-match trigger at 0x28, two post-trigger commits.
    trig_pc_en = 1'b1;
    trig_pc    = 32'h28;
    do_arm();
    check("t1_armed", armed, 1'b1);
    for (int k = 0; k < 20; k++) begin
      do_commit(32'(4 * k), 32'(4 * k + 4), 4'b0001, 5'd1, 32'h1000 + 32'(k), 32'h0, 1'b0);
      if (k == 7) begin
        check("t1_count_full", count, 8);
        check("t1_not_wrapped", wrapped, 1'b0);
      end
      if (k == 8) check("t1_wrapped", wrapped, 1'b1);
      if (k == 10) begin
        check("t1_trig_armed", armed, 1'b0);
        check("t1_trig_triggered", triggered, 1'b1);
        check("t1_trig_done", done, 1'b0);
      end
      if (k == 11) check("t1_post_done", done, 1'b0);
      if (k == 12) begin
        check("t1_done", done, 1'b1);
        check("t1_valid_lat", out_valid, 1'b0);
      end
      if (k == 13) check("t1_valid_rise", out_valid, 1'b1);
    end
    trig_pc_en = 1'b0;
    check("t1_count", count, 8);
    check("t1_wrapped_end", wrapped, 1'b1);

    // Backpressure: output held while ready is low.
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_pc", out_pc, 32'h14);
      tick();
    end
    drain_one("t1_e0", 32'h14, 4'b0001, 32'h1005);
    check("alt_count0", count, 7);
    tick();
    check("alt_hold_pc", out_pc, 32'h18);
    check("alt_hold_count", count, 7);
    drain_one("t1_e1", 32'h18, 4'b0001, 32'h1006);
    check("alt_count1", count, 6);
    tick();
    check("alt_hold_pc2", out_pc, 32'h1c);
    for (int i = 0; i < 6; i++)
      drain_one("t1_full", 32'h1c + 32'(4 * i), 4'b0001, 32'h1007 + 32'(i));
    check("t1_empty_valid", out_valid, 1'b0);
    check("t1_idle_done", done, 1'b0);
    check("t1_idle_trig", triggered, 1'b0);
    check("t1_idle_count", count, 0);

    // Trigger on the very first commit.
    do_arm();
    check("t2_wrapped_clr", wrapped, 1'b0);
    do_commit(32'h0, 32'h4, 4'b0000, 5'd0, 32'h0, 32'h0, 1'b1);
    check("t2_triggered", triggered, 1'b1);
    do_commit(32'h4, 32'h8, 4'b0000, 5'd0, 32'h0, 32'h0, 1'b0);
    do_commit(32'h8, 32'hc, 4'b0000, 5'd0, 32'h0, 32'h0, 1'b0);
    check("t2_done", done, 1'b1);
    do_commit(32'hc, 32'h10, 4'b0000, 5'd0, 32'h0, 32'h0, 1'b0);
    do_commit(32'h10, 32'h14, 4'b0000, 5'd0, 32'h0, 32'h0, 1'b0);
    check("t2_count", count, 3);
    check("t2_wrapped", wrapped, 1'b0);
    drain_one("t2_e0", 32'h0, 4'b0000, 32'h4);
    drain_one("t2_e1", 32'h4, 4'b0000, 32'h8);
    drain_one("t2_e2", 32'h8, 4'b0000, 32'hc);
    check("t2_empty_valid", out_valid, 1'b0);
    check("t2_idle_done", done, 1'b0);
    check("t2_idle_trig", triggered, 1'b0);
    check("t2_idle_armed", armed, 1'b0);

    // Entry flags/data, commits spaced three cycles apart.
    do_arm();
    do_commit(32'h40, 32'h44, 4'b0001, 5'd0, 32'hdead, 32'h0, 1'b0);
    tick(); tick();
    do_commit(32'h44, 32'h48, 4'b0010, 5'd0, 32'hbeef, 32'h100, 1'b0);
    tick(); tick();
    do_commit(32'h10, 32'h20, 4'b0100, 5'd0, 32'h0, 32'h0, 1'b1);
    tick(); tick();
    do_commit(32'h10, 32'h14, 4'b0100, 5'd0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    do_commit(32'h50, 32'h54, 4'b1000, 5'd0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    check("t3_count", count, 5);
    prev_cycle = out_cycle;
`ifndef TRACE_CYCLE_STAMP_EN
    check("t3_cycle0", out_cycle, 0);
`endif
    drain_one("t3_rd0", 32'h40, 4'b0000, 32'h44);
`ifdef TRACE_CYCLE_STAMP_EN
    check("t3_delta1", 16'(out_cycle - prev_cycle), 3);
`else
    check("t3_cycle1", out_cycle, 0);
`endif
    prev_cycle = out_cycle;
    drain_one("t3_sw", 32'h44, 4'b0010, 32'h100);
`ifdef TRACE_CYCLE_STAMP_EN
    check("t3_delta2", 16'(out_cycle - prev_cycle), 3);
`else
    check("t3_cycle2", out_cycle, 0);
`endif
    drain_one("t3_br_taken", 32'h10, 4'b0100, 32'h20);
    drain_one("t3_br_nt", 32'h10, 4'b0000, 32'h14);
    drain_one("t3_jump", 32'h50, 4'b1000, 32'h54);
    check("t3_empty_valid", out_valid, 1'b0);

    // Reset while in POST abandons the capture.
    do_arm();
    do_commit(32'h60, 32'h64, 4'b0000, 5'd0, 32'h0, 32'h0, 1'b1);
    check("t4_in_post", triggered, 1'b1);
    reset = 1'b1;
    tick();
    check("t4_armed", armed, 1'b0);
    check("t4_triggered", triggered, 1'b0);
    check("t4_done", done, 1'b0);
    check("t4_count", count, 0);
    check("t4_valid", out_valid, 1'b0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++)
      do_commit(32'h70 + 32'(4 * i), 32'h74 + 32'(4 * i), 4'b0000, 5'd0, 32'h0, 32'h0, 1'b1);
    check("t4_nocap_count", count, 0);
    check("t4_nocap_trig", triggered, 1'b0);
    check("t4_nocap_armed", armed, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
